// File: rtl/arb_rr_hold.sv
// arb_rr_hold: round-robin arbiter with a registered rotating priority
// pointer and a grant that stays stable while downstream stalls.
// Optional multi-beat lock is compiled in with `define ARB_RR_HOLD_LOCK_EN.
//
// Handshake: a beat transfers on a cycle where out_vld && out_rdy. The
// granted requester sees v_rdy high in exactly that cycle. The grant is a
// function of v_vld and registered state only; out_rdy never feeds v_grant.
module arb_rr_hold #(
   parameter int WIDTH = 4,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] v_vld,
   input  logic [WIDTH-1:0] v_last,
   output logic [WIDTH-1:0] v_rdy,
   output logic [WIDTH-1:0] v_grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             out_vld,
   output logic             out_last,
   input  logic             out_rdy
);

   logic [WIDTH-1:0]   ptr;
   logic               hold_vld;
   logic [WIDTH-1:0]   hold_grant;
   logic [2*WIDTH-1:0] dbl_req;
   logic [2*WIDTH-1:0] dbl_gnt;
   logic [WIDTH-1:0]   fresh_grant;
   logic [WIDTH-1:0]   sel_grant;
   logic               accept;
   logic               stall;
   logic               held_drop;
   logic               end_txn;

`ifdef ARB_RR_HOLD_LOCK_EN
   logic               lock_vld;
   logic [WIDTH-1:0]   lock_grant;
`endif

   // Fresh winner: first request at or above ptr, wrapping MSB -> bit 0.
   // Duplicating the request vector lets one subtract find the wrapped bit.
   always_comb begin
      dbl_req     = {v_vld, v_vld};
      dbl_gnt     = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, ptr});
      fresh_grant = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];
   end

   // Grant selection: lock beats hold beats fresh; a locked or held
   // requester that has dropped v_vld yields no grant this cycle.
   always_comb begin
      sel_grant = fresh_grant;
`ifdef ARB_RR_HOLD_LOCK_EN
      if (lock_vld)
         sel_grant = lock_grant;
      else if (hold_vld)
         sel_grant = hold_grant;
`else
      if (hold_vld)
         sel_grant = hold_grant;
`endif
      v_grant = sel_grant & v_vld;
   end

   // One-hot to binary index of the grant (0 when nothing is granted).
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v_grant[i])
            grant_idx = i[IDX_W-1:0];
      end
   end

   // Downstream view and per-requester accept.
   always_comb begin
      out_vld   = |v_grant;
      out_last  = |(v_grant & v_last);
      v_rdy     = v_grant & {WIDTH{out_rdy}};
      accept    = out_vld & out_rdy;
      stall     = out_vld & ~out_rdy;
      held_drop = hold_vld & ~|(hold_grant & v_vld);
`ifdef ARB_RR_HOLD_LOCK_EN
      end_txn   = out_last;
`else
      end_txn   = 1'b1;
`endif
   end

   // Pointer rotates past the winner once its transaction completes.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= {{(WIDTH-1){1'b0}}, 1'b1};
      else if (accept && end_txn)
         ptr <= {v_grant[WIDTH-2:0], v_grant[WIDTH-1]};
   end

   // Hold the grant across a stall; release on accept or when the held
   // requester withdraws its request.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld   <= 1'b0;
         hold_grant <= '0;
      end else if (stall) begin
         hold_vld   <= 1'b1;
         hold_grant <= v_grant;
      end else if (accept || held_drop) begin
         hold_vld   <= 1'b0;
      end
   end

`ifdef ARB_RR_HOLD_LOCK_EN
   // Keep a multi-beat burst on one requester until its last beat transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_vld   <= 1'b0;
         lock_grant <= '0;
      end else if (accept) begin
         if (out_last) begin
            lock_vld   <= 1'b0;
         end else begin
            lock_vld   <= 1'b1;
            lock_grant <= v_grant;
         end
      end
   end
`endif

endmodule

// File: tb/tb_arb_rr_hold.sv
// Directed bench for arb_rr_hold (WIDTH=4). Define ARB_RR_HOLD_LOCK_EN for
// both the design and the bench to exercise the burst-lock build.
module tb_arb_rr_hold;

   logic       clk;
   logic       rst;
   logic [3:0] v_vld;
   logic [3:0] v_last;
   logic [3:0] v_rdy;
   logic [3:0] v_grant;
   logic [1:0] grant_idx;
   logic       out_vld;
   logic       out_last;
   logic       out_rdy;

   int total = 0;
   int bad   = 0;

   arb_rr_hold #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .v_vld     (v_vld),
      .v_last    (v_last),
      .v_rdy     (v_rdy),
      .v_grant   (v_grant),
      .grant_idx (grant_idx),
      .out_vld   (out_vld),
      .out_last  (out_last),
      .out_rdy   (out_rdy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive inputs, then let combinational outputs settle
   task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic rdy);
      v_vld   = vld;
      v_last  = lst;
      out_rdy = rdy;
      #1;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // check the full output set against a hand-computed grant
   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                          input logic lst);
      chk({tag, ".grant"}, {4'h0, v_grant}, {4'h0, g});
      chk({tag, ".idx"}, {6'h0, grant_idx}, {6'h0, idx});
      chk({tag, ".vld"}, {7'h0, out_vld}, {7'h0, |g});
      chk({tag, ".last"}, {7'h0, out_last}, {7'h0, lst});
      chk({tag, ".rdy"}, {4'h0, v_rdy}, {4'h0, g & {4{out_rdy}}});
   endtask

   task automatic chk_ptr(input string tag, input logic [3:0] p);
      chk(tag, {4'h0, dut.ptr}, {4'h0, p});
   endtask

   initial begin : stim
      int seq [8];
      seq = '{0, 1, 2, 3, 0, 1, 2, 3};

      // reset
      rst = 1'b1;
      drive(4'b0000, 4'b0000, 1'b0);
      cyc();
      rst = 1'b0;
      #1;
      chk_out("reset", 4'b0000, 2'd0, 1'b0);
      chk_ptr("reset.ptr", 4'b0001);
      chk("reset.hold", {7'h0, dut.hold_vld}, 8'h0);

      // full rotation with every requester active
      for (int i = 0; i < 8; i++) begin
         drive(4'b1111, 4'b1111, 1'b1);
         chk_out($sformatf("rot%0d", i), 4'b0001 << seq[i], 2'(seq[i]), 1'b1);
         cyc();
         if (i == 0) chk_ptr("rot.ptr_after_first", 4'b0010);
      end
      chk_ptr("rot.ptr_end", 4'b0001);

      // wrap: ptr=0100, only 0 and 1 requesting
      drive(4'b1111, 4'b1111, 1'b1); cyc();
      drive(4'b1111, 4'b1111, 1'b1); cyc();
      chk_ptr("wrap.ptr", 4'b0100);
      drive(4'b0011, 4'b1111, 1'b1);
      chk_out("wrap.a", 4'b0001, 2'd0, 1'b1);
      cyc();
      drive(4'b0011, 4'b1111, 1'b1);
      chk_out("wrap.b", 4'b0010, 2'd1, 1'b1);
      cyc();
      chk_ptr("wrap.ptr_end", 4'b0100);

      // move ptr to 0010 (grants 2,3,0)
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 4'b1111, 1'b1); cyc();
      end
      chk_ptr("stall.ptr_pre", 4'b0010);

      // stall on requester 1 for 3 cycles; requester 3 rises in cycle 2
      drive(4'b0110, 4'b1111, 1'b0);
      chk_out("stall.c1", 4'b0010, 2'd1, 1'b1);
      cyc();
      drive(4'b1110, 4'b1111, 1'b0);
      chk_out("stall.c2", 4'b0010, 2'd1, 1'b1);
      cyc();
      drive(4'b1110, 4'b1111, 1'b0);
      chk_out("stall.c3", 4'b0010, 2'd1, 1'b1);
      chk_ptr("stall.ptr", 4'b0010);
      cyc();
      drive(4'b1110, 4'b1111, 1'b1);
      chk_out("stall.acc", 4'b0010, 2'd1, 1'b1);
      cyc();
      drive(4'b1110, 4'b1111, 1'b1);
      chk_out("stall.next", 4'b0100, 2'd2, 1'b1);
      cyc();
      chk_ptr("stall.ptr_end", 4'b1000);

      // held requester withdraws: no grant, then fresh arbitration
      drive(4'b1110, 4'b1111, 1'b0);
      chk_out("drop.held", 4'b1000, 2'd3, 1'b1);
      cyc();
      drive(4'b0110, 4'b1111, 1'b0);
      chk_out("drop.gone", 4'b0000, 2'd0, 1'b0);
      cyc();
      chk("drop.hold_clr", {7'h0, dut.hold_vld}, 8'h0);
      drive(4'b0110, 4'b1111, 1'b0);
      chk_out("drop.fresh", 4'b0010, 2'd1, 1'b1);
      cyc();
      drive(4'b0110, 4'b1111, 1'b1);
      chk_out("drop.acc", 4'b0010, 2'd1, 1'b1);
      cyc();
      chk_ptr("drop.ptr", 4'b0100);

`ifdef ARB_RR_HOLD_LOCK_EN
      // burst of 3 beats from requester 2 keeps the grant
      drive(4'b1111, 4'b1011, 1'b1);
      chk_out("burst.b0", 4'b0100, 2'd2, 1'b0);
      cyc();
      drive(4'b1111, 4'b1011, 1'b1);
      chk_out("burst.b1", 4'b0100, 2'd2, 1'b0);
      cyc();
      drive(4'b1111, 4'b1111, 1'b1);
      chk_out("burst.b2", 4'b0100, 2'd2, 1'b1);
      cyc();
      drive(4'b1111, 4'b1111, 1'b1);
      chk_out("burst.after", 4'b1000, 2'd3, 1'b1);
      cyc();
      chk_ptr("burst.ptr", 4'b0001);

      // lock on requester 1 survives a 2-cycle request gap
      drive(4'b0010, 4'b0000, 1'b1);
      chk_out("lock.b0", 4'b0010, 2'd1, 1'b0);
      cyc();
      chk("lock.set", {7'h0, dut.lock_vld}, 8'h1);
      for (int i = 0; i < 2; i++) begin
         drive(4'b1101, 4'b1111, 1'b1);
         chk_out($sformatf("lock.gap%0d", i), 4'b0000, 2'd0, 1'b0);
         cyc();
      end
      chk("lock.kept", {7'h0, dut.lock_vld}, 8'h1);
      drive(4'b1111, 4'b0010, 1'b1);
      chk_out("lock.b1", 4'b0010, 2'd1, 1'b1);
      cyc();
      chk("lock.clr", {7'h0, dut.lock_vld}, 8'h0);
      drive(4'b1111, 4'b1111, 1'b1);
      chk_out("lock.next", 4'b0100, 2'd2, 1'b1);
      cyc();
`else
      // without lock, beats interleave with other requesters
      drive(4'b1111, 4'b1011, 1'b1);
      chk_out("burst.b0", 4'b0100, 2'd2, 1'b0);
      cyc();
      drive(4'b1111, 4'b1011, 1'b1);
      chk_out("burst.b1", 4'b1000, 2'd3, 1'b1);
      cyc();
      drive(4'b1111, 4'b1011, 1'b1);
      chk_out("burst.b2", 4'b0001, 2'd0, 1'b1);
      cyc();
      drive(4'b1111, 4'b1011, 1'b1);
      chk_out("burst.b3", 4'b0010, 2'd1, 1'b1);
      cyc();
      chk_ptr("burst.ptr", 4'b0100);

      // a non-last accept does not pin the requester
      drive(4'b0010, 4'b0000, 1'b1);
      chk_out("nolock.b0", 4'b0010, 2'd1, 1'b0);
      cyc();
      drive(4'b1111, 4'b1111, 1'b1);
      chk_out("nolock.next", 4'b0100, 2'd2, 1'b1);
      cyc();
`endif
      chk_ptr("pre_rst.ptr", 4'b1000);

      // reset wins over a simultaneous accept mid-transaction
      drive(4'b1111, 4'b0000, 1'b1);
      chk_out("rst.pre", 4'b1000, 2'd3, 1'b0);
      cyc();
      drive(4'b1111, 4'b0000, 1'b0);
      cyc();
      rst = 1'b1;
      drive(4'b1111, 4'b0000, 1'b1);
      cyc();
      rst = 1'b0;
      drive(4'b1111, 4'b1111, 1'b0);
      chk_ptr("rst.ptr", 4'b0001);
      chk("rst.hold", {7'h0, dut.hold_vld}, 8'h0);
`ifdef ARB_RR_HOLD_LOCK_EN
      chk("rst.lock", {7'h0, dut.lock_vld}, 8'h0);
`endif
      chk_out("rst.post", 4'b0001, 2'd0, 1'b1);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
